ntt_bfly_addsub: RTL and testbench
==================================

// Module: ntt_bfly_addsub
// PURPOSE
// - Cooley-Tukey butterfly back-end for the Kyber NTT datapath (q = 3329), directly downstream of the Barrett reducer.
// - Consumes the reducer's output R = (w*b) mod q.
// - Aligns R with the matching a operand through an internal delay line.
// - Emits a' = (a + R) mod q and b' = (a - R) mod q, both registered.
// - Counts butterflies and flags the last one of an NTT layer.
// PARAMETERS
// - Q        3329  modulus
// - DW       12    coefficient width, a/sum/diff
// - RW       13    width of R_i, equal to the reducer output width
// - LAT      2     reducer latency in cycles, from C launch to R valid; range 1..8
// - N_BFLY   128   butterflies per layer; last_o period
// PORTS
// - clk_i      in   1     clock, rising edge
// - rst_ni     in   1     asynchronous reset, active low
// - start_i    in   1     synchronous layer start; clears butterfly counter
// - valid_i    in   1     a_i valid; same cycle the product C is launched into the reducer
// - a_i        in   DW    upper butterfly operand, 0..Q-1
// - R_i        in   RW    reducer output, valid LAT cycles after valid_i
// - valid_o    out  1     sum_o/diff_o valid
// - sum_o      out  DW    (a + R) mod Q
// - diff_o     out  DW    (a - R) mod Q
// - last_o     out  1     high with the N_BFLY-th valid_o of the layer
// - err_o      out  1     sticky range error (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst_ni=0): all delay-line stages, valid pipe, counter and outputs are 0.
//   - A reset mid-layer drops in-flight butterflies; no valid_o follows release.
// - Delay line: LAT-stage shift register of {valid, a}, advancing every cycle; no stall or backpressure.
//   - Stage LAT pairs with R_i in the same cycle.
// - Arithmetic on the aligned pair (a_d, R_i), unsigned:
//   - s = a_d + R_i (14 b): sum = (s >= Q) ? s - Q : s.
//   - d = a_d - R_i (14 b signed): diff = (d < 0) ? d + Q : d.
//   - Results truncated to DW; exact for a_d, R_i in 0..Q-1.
// - Output register: valid_o, sum_o, diff_o, last_o updated on the clock.
//   - Total latency: valid_i at cycle t gives valid_o at t+LAT+1.
//   - Throughput: one butterfly per cycle.
// - When the aligned valid is 0:
//   - valid_o=0 and last_o=0.
//   - sum_o/diff_o hold their previous values.
// - Counter cnt (0..N_BFLY-1) increments on each output-register load with valid.
//   - last_o=1 on the load where cnt==N_BFLY-1; cnt then wraps to 0.
// - start_i: cnt is cleared.
//   - If an aligned valid occurs in the same cycle, that butterfly counts as index 0 and cnt becomes 1.
//   - start_i does not flush the delay line.
// - Back-to-back layers: last_o of layer k and index 0 of layer k+1 may be on adjacent cycles.
// CONFIGURATION
// - Macro NTT_BFLY_RANGE_CHK_EN.
// - Defined:
//   - Each cycle the aligned valid is 1, err_o sets (sticky) if a_d >= Q or R_i >= Q.
//   - err_o is cleared only by reset or start_i; start_i wins over a same-cycle set.
//   - Outputs are still produced from the truncated arithmetic.
// - Undefined: no checker logic; err_o tied to 0.
// TESTING
// - Reset: hold rst_ni=0 with valid_i toggling -> valid_o=last_o=err_o=0, sum_o=diff_o=0.
// - a=100, R=3300 (LAT=2) -> 3 cycles after valid_i: valid_o=1, sum_o=71, diff_o=129.
// - Edge values:
//   - a=0, R=1 -> sum_o=1, diff_o=3328.
//   - a=3328, R=3328 -> sum_o=3327, diff_o=0.
//   - a=0, R=0 -> sum_o=0, diff_o=0.
// - Streaming: 128 consecutive valid_i after start_i -> 128 consecutive valid_o.
//   - last_o only on the 128th.
//   - A second 128 then yields last_o again on its 128th.
// - Mid-layer: assert rst_ni=0 after 50 inputs, release, start_i, 128 inputs -> no stale valid_o; last_o on the 128th.
// - With NTT_BFLY_RANGE_CHK_EN: R_i=3329 on an aligned valid -> err_o=1 next cycle, held until start_i.
//   - Without the macro, err_o stays 0.

Source files
------------

// File: rtl/ntt_bfly_addsub.sv
// Kyber NTT butterfly back-end: it aligns a with the reduced product R and emits (a+R) mod q and (a-R) mod q.
// Optional range checker: define NTT_BFLY_RANGE_CHK_EN to get a sticky err_o on out-of-range operands.
module ntt_bfly_addsub #(
   parameter int Q      = 3329,
   parameter int DW     = 12,
   parameter int RW     = 13,
   parameter int LAT    = 2,
   parameter int N_BFLY = 128
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic          valid_i,
   input  logic [DW-1:0] a_i,
   input  logic [RW-1:0] R_i,
   output logic          valid_o,
   output logic [DW-1:0] sum_o,
   output logic [DW-1:0] diff_o,
   output logic          last_o,
   output logic          err_o
);

   localparam int             SW    = RW + 1;
   localparam int             CW    = (N_BFLY > 1) ? $clog2(N_BFLY) : 1;
   localparam logic [SW-1:0]  Q_EXT = SW'(Q);
   localparam logic [CW-1:0]  CNT_LAST = CW'(N_BFLY - 1);

   logic [LAT-1:0] vld_q;
   logic [DW-1:0]  a_q [LAT];
   logic [CW-1:0]  cnt_q;

   logic          v_d;
   logic [SW-1:0] a_ext, r_ext, s, d, s_mod, d_mod;
   logic [CW-1:0] cnt_base, cnt_d;
   logic          at_last;

   // NOTE: the delay line is a shift register, not a RAM, so every stage is reset;
   // a reset mid-layer must not let stale valids reach the output.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) a_q[i] <= '0;
      end else begin
         // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
         vld_q[0] <= valid_i;
         a_q[0]   <= a_i;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            a_q[i]   <= a_q[i-1];
         end
      end
   end

   assign v_d   = vld_q[LAT-1];
   assign a_ext = {{(SW-DW){1'b0}}, a_q[LAT-1]};
   assign r_ext = {{(SW-RW){1'b0}}, R_i};

   // NOTE: every signal is given a default first, so no latch can be inferred.
   always_comb begin
      s        = a_ext + r_ext;
      d        = a_ext - r_ext;
      s_mod    = (s >= Q_EXT) ? s - Q_EXT : s;
      d_mod    = d[SW-1] ? d + Q_EXT : d;
      cnt_base = start_i ? '0 : cnt_q;
      at_last  = (cnt_base == CNT_LAST);
      cnt_d    = cnt_base;
      if (v_d) cnt_d = at_last ? '0 : cnt_base + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
         last_o  <= 1'b0;
         sum_o   <= '0;
         diff_o  <= '0;
         cnt_q   <= '0;
      end else begin
         valid_o <= v_d;
         last_o  <= v_d & at_last;
         cnt_q   <= cnt_d;
         if (v_d) begin
            sum_o  <= s_mod[DW-1:0];
            diff_o <= d_mod[DW-1:0];
         end
      end
   end

`ifdef NTT_BFLY_RANGE_CHK_EN
   logic err_q;
   logic range_bad;

   assign range_bad = v_d & ((a_ext >= Q_EXT) | (r_ext >= Q_EXT));

   // start_i takes priority so a fresh layer never inherits an error from the same cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)        err_q <= 1'b0;
      else if (start_i)   err_q <= 1'b0;
      else if (range_bad) err_q <= 1'b1;
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_bfly_addsub.sv
// Directed bench for ntt_bfly_addsub: reset, hand vectors, layer streaming, mid-layer reset, range checker.
module tb_ntt_bfly_addsub;

   localparam int Q   = 3329;
   localparam int LAT = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni, start_i, valid_i;
   logic [11:0] a_i;
   logic [12:0] R_i;
   logic        valid_o, last_o, err_o;
   logic [11:0] sum_o, diff_o;

   int tests = 0;
   int fails = 0;

   logic [12:0] r_dly [LAT];
   logic        mon_en = 1'b0;
   int          cyc = 0;
   int          vcount, mism, first_cyc, last_cyc;
   int          last_pos[$];
   logic [23:0] exp_q[$];

   ntt_bfly_addsub dut (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .start_i (start_i),
      .valid_i (valid_i),
      .a_i     (a_i),
      .R_i     (R_i),
      .valid_o (valid_o),
      .sum_o   (sum_o),
      .diff_o  (diff_o),
      .last_o  (last_o),
      .err_o   (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] model(input int a, input int r);
      int s, d;
      s = a + r;
      if (s >= Q) s -= Q;
      d = a - r;
      if (d < 0) d += Q;
      return {12'(s), 12'(d)};
   endfunction

   task automatic clear_mon();
      vcount = 0; mism = 0; first_cyc = -1; last_cyc = -1;
      last_pos.delete();
      exp_q.delete();
   endtask

   // One clock cycle: R is fed LAT cycles after the a it belongs to, outputs sampled 1 ns after the edge.
   task automatic step(input logic st, input logic v, input int a, input int r);
      logic [23:0] e;
      start_i = st;
      valid_i = v;
      a_i     = 12'(a);
      R_i     = r_dly[LAT-1];
      if (v && mon_en) exp_q.push_back(model(a, r));
      @(posedge clk_i);
      #1;
      for (int i = LAT - 1; i > 0; i--) r_dly[i] = r_dly[i-1];
      r_dly[0] = 13'(r);
      cyc++;
      if (mon_en && valid_o) begin
         vcount++;
         if (first_cyc < 0) first_cyc = cyc;
         last_cyc = cyc;
         if (exp_q.size() == 0) mism++;
         else begin
            e = exp_q.pop_front();
            if ({sum_o, diff_o} !== e) mism++;
         end
         if (last_o) last_pos.push_back(vcount);
      end else if (mon_en && last_o) mism++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0);
   endtask

   task automatic check_layer(input string tag, input int n_exp, input int n_last);
      check({tag, "_vcount"}, vcount, n_exp);
      check({tag, "_back2back"}, last_cyc - first_cyc + 1, n_exp);
      check({tag, "_data_mism"}, mism, 0);
      check({tag, "_nlast"}, last_pos.size(), n_last);
      check({tag, "_last0"}, (last_pos.size() > 0) ? last_pos[0] : -1, 128);
   endtask

   initial begin
      for (int i = 0; i < LAT; i++) r_dly[i] = '0;
      clear_mon();
      rst_ni = 1'b0; start_i = 1'b0; valid_i = 1'b0; a_i = '0; R_i = '0;

      // Reset held with valid toggling
      for (int i = 0; i < 4; i++) step(1'b0, i[0], 100 + i, 3300);
      check("rst_valid", valid_o, 0);
      check("rst_last", last_o, 0);
      check("rst_err", err_o, 0);
      check("rst_sum", sum_o, 0);
      check("rst_diff", diff_o, 0);
      rst_ni = 1'b1;
      for (int i = 0; i < LAT; i++) r_dly[i] = '0;
      idle(LAT + 2);
      check("rst_release_valid", valid_o, 0);

      // a=100, R=3300: result LAT+1 cycles later
      step(1'b1, 1'b1, 100, 3300);
      step(1'b0, 1'b0, 0, 0);
      check("lat_early", valid_o, 0);
      step(1'b0, 1'b0, 0, 0);
      check("v1_valid", valid_o, 1);
      check("v1_sum", sum_o, 71);
      check("v1_diff", diff_o, 129);
      check("v1_last", last_o, 0);
      step(1'b0, 1'b0, 0, 0);
      check("hold_valid", valid_o, 0);
      check("hold_sum", sum_o, 71);
      check("hold_diff", diff_o, 129);

      // Edge values back to back
      step(1'b0, 1'b1, 0, 1);
      step(1'b0, 1'b1, 3328, 3328);
      step(1'b0, 1'b1, 0, 0);
      check("e1_sum", sum_o, 1);
      check("e1_diff", diff_o, 3328);
      step(1'b0, 1'b0, 0, 0);
      check("e2_sum", sum_o, 3327);
      check("e2_diff", diff_o, 0);
      step(1'b0, 1'b0, 0, 0);
      check("e3_valid", valid_o, 1);
      check("e3_sum", sum_o, 0);
      check("e3_diff", diff_o, 0);
      idle(2);

      // Two back-to-back layers of 128
      clear_mon();
      mon_en = 1'b1;
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 256; i++) step(1'b0, 1'b1, (i * 37) % Q, (i * 101 + 5) % Q);
      idle(LAT + 3);
      check_layer("two_layers", 256, 2);
      check("two_layers_last1", (last_pos.size() > 1) ? last_pos[1] : -1, 256);

      // Reset mid-layer after 50 inputs
      mon_en = 1'b0;
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, (i * 53) % Q, (i * 7) % Q);
      clear_mon();
      mon_en = 1'b1;
      rst_ni = 1'b0;
      step(1'b0, 1'b0, 0, 0);
      rst_ni = 1'b1;
      idle(LAT + 2);
      check("mid_no_stale", vcount, 0);
      step(1'b1, 1'b0, 0, 0);
      for (int i = 0; i < 128; i++) step(1'b0, 1'b1, 3328 - (i * 11) % Q, (i * 29) % Q);
      idle(LAT + 3);
      check_layer("mid_layer", 128, 1);
      mon_en = 1'b0;

      // Out-of-range R on an aligned valid
      step(1'b0, 1'b1, 5, 3329);
      idle(LAT);
`ifdef NTT_BFLY_RANGE_CHK_EN
      check("err_set", err_o, 1);
      idle(3);
      check("err_held", err_o, 1);
      step(1'b1, 1'b0, 0, 0);
      check("err_cleared", err_o, 0);
`else
      check("err_tied", err_o, 0);
      idle(3);
      check("err_tied_late", err_o, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
